vga_timing_gen: RTL and testbench

Free-running video timing generator that produces the raster counters and sync/data-valid strobes for the 1600x900 display pipeline. It is the stage directly upstream of the pixel-processing datapath and the regression tester. Both consume vga_dv_o, vga_hs_o, vga_vs_o, h_cnt and v_cnt to pace pixel injection and capture. Default timing is VESA DMT 1600x900@60 at a 108 MHz pixel clock.

---
 rtl/vga_timing_gen.sv | 73 +++++++
 tb/tb_vga_timing_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters with registered sync, data-valid and frame-start strobes.
// Strobes are decoded from the next-state counters, so they stay cycle-aligned with h_cnt/v_cnt.
module vga_timing_gen #(
    parameter int   HRES   = 1600,
    parameter int   HFP    = 24,
    parameter int   HSYNC  = 80,
    parameter int   HBP    = 96,
    parameter int   VRES   = 900,
    parameter int   VFP    = 1,
    parameter int   VSYNC  = 3,
    parameter int   VBP    = 96,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] h_cnt,
    output logic [10:0] v_cnt,
    output logic        vga_dv_o,
    output logic        vga_hs_o,
    output logic        vga_vs_o,
    output logic        frame_start_o
);
    localparam int HTOT = HRES + HFP + HSYNC + HBP;
    localparam int VTOT = VRES + VFP + VSYNC + VBP;

    if (HTOT > 2048 || VTOT > 2048) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: HTOT=%0d VTOT=%0d exceed the 11-bit counters", HTOT, VTOT);
    end

    localparam logic [10:0] H_LAST = 11'(HTOT - 1);
    localparam logic [10:0] V_LAST = 11'(VTOT - 1);
    // 12-bit thresholds so an active width of exactly 2048 still compares correctly
    localparam logic [11:0] H_ACT  = 12'(HRES);
    localparam logic [11:0] H_SS   = 12'(HRES + HFP);
    localparam logic [11:0] H_SE   = 12'(HRES + HFP + HSYNC);
    localparam logic [11:0] V_ACT  = 12'(VRES);
    localparam logic [11:0] V_SS   = 12'(VRES + VFP);
    localparam logic [11:0] V_SE   = 12'(VRES + VFP + VSYNC);

    logic        h_wrap;
    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic [11:0] hx;
    logic [11:0] vx;

    always_comb begin
        h_wrap = h_cnt == H_LAST;
        h_nxt  = h_wrap ? 11'd0 : h_cnt + 11'd1;
        v_nxt  = !h_wrap ? v_cnt : (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        hx     = {1'b0, h_nxt};
        vx     = {1'b0, v_nxt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt         <= H_LAST;
            v_cnt         <= V_LAST;
            vga_dv_o      <= 1'b0;
            vga_hs_o      <= ~HS_POL;
            vga_vs_o      <= ~VS_POL;
            frame_start_o <= 1'b0;
        end else if (en) begin
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            vga_dv_o      <= (hx < H_ACT) && (vx < V_ACT);
            vga_hs_o      <= ((hx >= H_SS) && (hx < H_SE)) ? HS_POL : ~HS_POL;
            vga_vs_o      <= ((vx >= V_SS) && (vx < V_SE)) ? VS_POL : ~VS_POL;
            frame_start_o <= (h_nxt == 11'd0) && (v_nxt == 11'd0);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the default 1600x900 timing plus a shrunken raster
// (HTOT=25, VTOT=14) that lets whole frames and mid-frame resets run in few cycles.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst0, en0, rst1, en1;
    logic [10:0] h0, v0, h1, v1, h2, v2;
    logic dv0, hs0, vs0, fs0, dv1, hs1, vs1, fs1, dv2, hs2, vs2, fs2;
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    vga_timing_gen u0 (.clk(clk), .rst(rst0), .en(en0), .h_cnt(h0), .v_cnt(v0),
        .vga_dv_o(dv0), .vga_hs_o(hs0), .vga_vs_o(vs0), .frame_start_o(fs0));

    vga_timing_gen #(.HRES(16), .HFP(2), .HSYNC(3), .HBP(4), .VRES(8), .VFP(1), .VSYNC(2), .VBP(3))
    u1 (.clk(clk), .rst(rst1), .en(en1), .h_cnt(h1), .v_cnt(v1),
        .vga_dv_o(dv1), .vga_hs_o(hs1), .vga_vs_o(vs1), .frame_start_o(fs1));

    vga_timing_gen #(.HRES(16), .HFP(2), .HSYNC(3), .HBP(4), .VRES(8), .VFP(1), .VSYNC(2), .VBP(3),
        .HS_POL(1'b0), .VS_POL(1'b0))
    u2 (.clk(clk), .rst(rst1), .en(en1), .h_cnt(h2), .v_cnt(v2),
        .vga_dv_o(dv2), .vga_hs_o(hs2), .vga_vs_o(vs2), .frame_start_o(fs2));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input int h, input int v, input int dv, input int hs,
                        input int vs, input int fs);
        chk({tag, ".h"}, int'(h0), h);
        chk({tag, ".v"}, int'(v0), v);
        chk({tag, ".dv"}, int'(dv0), dv);
        chk({tag, ".hs"}, int'(hs0), hs);
        chk({tag, ".vs"}, int'(vs0), vs);
        chk({tag, ".fs"}, int'(fs0), fs);
    endtask

    task automatic chk1(input string tag, input int h, input int v, input int dv, input int hs,
                        input int vs, input int fs);
        chk({tag, ".h"}, int'(h1), h);
        chk({tag, ".v"}, int'(v1), v);
        chk({tag, ".dv"}, int'(dv1), dv);
        chk({tag, ".hs"}, int'(hs1), hs);
        chk({tag, ".vs"}, int'(vs1), vs);
        chk({tag, ".fs"}, int'(fs1), fs);
        chk({tag, ".inv_h"}, int'(h2), h);
        chk({tag, ".inv_v"}, int'(v2), v);
        chk({tag, ".inv_dv"}, int'(dv2), dv);
        chk({tag, ".inv_hs"}, int'(hs2), 1 - hs);
        chk({tag, ".inv_vs"}, int'(vs2), 1 - vs);
        chk({tag, ".inv_fs"}, int'(fs2), fs);
    endtask

    initial begin
        int n_dv, n_hs, n_hs_rise, n_vs, n_fs, n_hs_inv;
        logic prev_hs;
        rst0 = 1'b1; en0 = 1'b1; rst1 = 1'b1; en1 = 1'b1;
        step(3);
        chk0("reset", 1799, 999, 0, 0, 0, 0);
        rst0 = 1'b0;
        step(1);
        chk0("first", 0, 0, 1, 0, 0, 1);
        step(1599);
        chk0("last_active", 1599, 0, 1, 0, 0, 0);
        step(1);
        chk0("hfp_start", 1600, 0, 0, 0, 0, 0);
        step(23);
        chk0("pre_hsync", 1623, 0, 0, 0, 0, 0);
        step(1);
        chk0("hsync_start", 1624, 0, 0, 1, 0, 0);
        step(79);
        chk0("hsync_end", 1703, 0, 0, 1, 0, 0);
        step(1);
        chk0("post_hsync", 1704, 0, 0, 0, 0, 0);
        step(95);
        chk0("line_end", 1799, 0, 0, 0, 0, 0);
        step(1);
        chk0("line1", 0, 1, 1, 0, 0, 0);
        step(9 * 1800 + 1599);
        chk0("pre_hold", 1599, 10, 1, 0, 0, 0);
        en0 = 1'b0;
        step(7);
        chk0("hold", 1599, 10, 1, 0, 0, 0);
        en0 = 1'b1;
        step(1);
        chk0("resume", 1600, 10, 0, 0, 0, 0);

        // shrunken raster: reset, then one full frame of statistics
        chk1("s_reset", 24, 13, 0, 0, 0, 0);
        rst1 = 1'b0;
        n_dv = 0; n_hs = 0; n_hs_rise = 0; n_vs = 0; n_fs = 0; n_hs_inv = 0;
        prev_hs = 1'b0;
        for (int i = 0; i < 350; i++) begin
            step(1);
            n_dv += int'(dv1);
            n_hs += int'(hs1);
            n_hs_rise += int'(hs1 && !prev_hs);
            n_vs += int'(vs1);
            n_fs += int'(fs1);
            n_hs_inv += int'(!hs2);
            prev_hs = hs1;
        end
        chk("frame_dv", n_dv, 128);
        chk("frame_hs_cycles", n_hs, 42);
        chk("frame_hs_pulses", n_hs_rise, 14);
        chk("frame_vs_cycles", n_vs, 50);
        chk("frame_fs", n_fs, 1);
        chk("frame_hs_inv", n_hs_inv, 42);
        chk1("s_frame_end", 24, 13, 0, 0, 0, 0);
        step(1);
        chk1("s_wrap", 0, 0, 1, 0, 0, 1);
        step(8 * 25);
        chk1("s_vfp", 0, 8, 0, 0, 0, 0);
        step(25);
        chk1("s_vs_start", 0, 9, 0, 0, 1, 0);
        step(49);
        chk1("s_vs_end", 24, 10, 0, 0, 1, 0);
        step(1);
        chk1("s_post_vs", 0, 11, 0, 0, 0, 0);
        step(74);
        chk1("s_frame_end2", 24, 13, 0, 0, 0, 0);
        step(1 + 5 * 25 + 8);
        chk1("s_mid", 8, 5, 1, 0, 0, 0);
        rst1 = 1'b1;
        step(1);
        chk1("s_mid_reset", 24, 13, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
